// File: rtl/sm_pio_pkg.sv
// Shared definitions for the SM PIO output port: register map, CTRL bit layout, sequencer states.
package sm_pio_pkg;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_SET  = 2'd1;
    localparam logic [1:0] ADDR_CLR  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_SYNC_MODE = 0;
    localparam int CTRL_PENDING   = 1;
    localparam int CTRL_FORCE     = 2;
    localparam int CTRL_IRQ_EN    = 3;
    localparam int CTRL_IRQ_CLR   = 4;

    typedef enum logic {IDLE, DEAD} state_t;
endpackage

// File: rtl/sm_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input with a one-cycle rising-edge pulse.
module sm_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;
endmodule

// File: rtl/sm_pio_out_seq.sv
// Avalon-MM output port with shadow register, atomic set/clear, sync-edge update,
// break-before-make dead time and completion interrupt.
module sm_pio_out_seq
    import sm_pio_pkg::*;
#(
    parameter int          WIDTH       = 2,
    parameter logic [31:0] RESET_VALUE = 0,
    parameter int          DEAD_CYCLES = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic             sync_in,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    localparam int CW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam logic [WIDTH-1:0] RST      = RESET_VALUE[WIDTH-1:0];
    localparam logic [CW-1:0]    CNT_INIT = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_out, r_shadow, r_target;
    logic [WIDTH-1:0] w_out_nxt, w_shadow_nxt, w_wd;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_pending, r_sync_mode, r_irq_en, r_force, r_irq_status;
    logic             w_wr, w_ctrl_wr, w_shadow_wr, w_sync_rise, w_apply, w_done;
    logic             w_unused_wd;

    sm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (sync_in),
        .o_rise  (w_sync_rise)
    );

    assign w_wr        = chipselect & ~write_n;
    assign w_ctrl_wr   = w_wr & (address == ADDR_CTRL);
    assign w_shadow_wr = w_wr & (address != ADDR_CTRL);
    assign w_wd        = writedata[WIDTH-1:0];
    // Data bits at or above WIDTH are intentionally dropped.
    assign w_unused_wd = ^writedata;

    always_comb begin
        w_shadow_nxt = r_shadow;
        case (address)
            ADDR_DATA: w_shadow_nxt = w_wd;
            ADDR_SET:  w_shadow_nxt = r_shadow | w_wd;
            ADDR_CLR:  w_shadow_nxt = r_shadow & ~w_wd;
            default:   w_shadow_nxt = r_shadow;
        endcase
    end

    assign w_apply = (r_state == IDLE) & r_pending & (~r_sync_mode | w_sync_rise | r_force);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_apply) begin
                    if (DEAD_CYCLES == 0 || r_shadow == r_out) begin
                        w_out_nxt = r_shadow;
                        w_done    = 1'b1;
                    end else begin
                        w_out_nxt   = '0;
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = DEAD;
                    end
                end
            end
            DEAD: begin
                if (r_cnt == '0) begin
                    w_out_nxt   = r_target;
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out        <= RST;
            r_shadow     <= RST;
            r_target     <= RST;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_sync_mode  <= 1'b0;
            r_irq_en     <= 1'b0;
            r_force      <= 1'b0;
            r_irq_status <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_apply) r_target <= r_shadow;
            // A shadow write coinciding with apply keeps the new value pending.
            if (w_shadow_wr) begin
                r_shadow  <= w_shadow_nxt;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
            r_force <= w_ctrl_wr & writedata[CTRL_FORCE];
            if (w_ctrl_wr) begin
                r_sync_mode <= writedata[CTRL_SYNC_MODE];
                r_irq_en    <= writedata[CTRL_IRQ_EN];
            end
            if (w_done)                                  r_irq_status <= 1'b1;
            else if (w_ctrl_wr & writedata[CTRL_IRQ_CLR]) r_irq_status <= 1'b0;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = r_out;
            ADDR_SET:  readdata[WIDTH-1:0] = r_shadow;
            ADDR_CLR:  readdata[0]         = r_irq_status;
            ADDR_CTRL: begin
                readdata[CTRL_SYNC_MODE] = r_sync_mode;
                readdata[CTRL_PENDING]   = r_pending;
                readdata[CTRL_IRQ_EN]    = r_irq_en;
            end
            default: readdata = '0;
        endcase
    end

    assign out_port = r_out;
    assign irq      = r_irq_status & r_irq_en;
endmodule

// File: doc/sm_pio_out_seq.md
Name: sm_pio_out_seq

Overview:
- Parametrised Avalon-MM output port; successor to the 2-bit SM mux select port.
- Adds configurable width, a shadow register, atomic bit set/clear, and optional update on an external sync edge (e.g. TFT frame boundary).
- Adds break-before-make dead time and a completion interrupt.
- Sits on the SM_MCU Avalon bus; drives mux/enable selects in the sensor-to-TFT path.

Parameters:
- WIDTH, 2, out_port width, 1..32.
- RESET_VALUE, 0, out_port and shadow value at reset.
- DEAD_CYCLES, 4, cycles out_port is forced to 0 between differing values; 0 disables.
- SYNC_STAGES, 2, synchroniser depth for sync_in, >=2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data.
- sync_in  in  1  asynchronous update trigger; rising edge used.
- out_port  out  WIDTH  registered output.
- irq  out  1  level interrupt.

Behaviour:
- Reset: out_port=RESET_VALUE, shadow=RESET_VALUE, pending=0, ctrl=0, irq_status=0, FSM=IDLE. Reset is asynchronous and aborts any sequence in progress.
- Write strobe: chipselect & ~write_n.
- addr0 DATA: W shadow<=wd[WIDTH-1:0]; R out_port, zero-extended.
- addr1 SET: W shadow<=shadow|wd; R shadow.
- addr2 CLR: W shadow<=shadow&~wd; R {31'b0, irq_status}.
- addr3 CTRL: bit0 SYNC_MODE (rw), bit1 PENDING (ro), bit2 FORCE (wo, self-clearing pulse), bit3 IRQ_EN (rw), bit4 IRQ_CLR (W1C of irq_status). R {27'b0, 0, IRQ_EN, 0, pending, SYNC_MODE}.
- Any DATA/SET/CLR write sets pending at the same edge.
- sync_rise: SYNC_STAGES-FF synchroniser plus rising-edge detect on sync_in; 1-cycle pulse.
- Apply condition, evaluated in IDLE only: pending & (~SYNC_MODE | sync_rise | FORCE).
- On apply: target<=shadow and pending<=0, unless a shadow write occurs the same cycle. In that case pending stays 1, the write lands in shadow, and target takes the pre-write shadow.
- FSM IDLE, apply, DEAD_CYCLES==0 or target==out_port: out_port<=shadow at the same edge; done pulse; stay IDLE.
- FSM IDLE, apply, otherwise: out_port<=0, cnt<=DEAD_CYCLES-1, go to DEAD.
- FSM DEAD: cnt decrements each cycle. At cnt==0: out_port<=target, done pulse, go to IDLE.
- Result: out_port holds 0 for exactly DEAD_CYCLES cycles.
- Latency, immediate mode: write at edge E0; out_port final value at E1 (no dead time) or E1+DEAD_CYCLES.
- Writes during DEAD update shadow and set pending; they do not alter target. The next apply is evaluated on the first IDLE cycle after completion.
- sync_rise or FORCE while in DEAD, or while pending==0: ignored, not queued.
- Changing SYNC_MODE 1->0 with pending set: apply fires the next IDLE cycle.
- done sets irq_status. If set and IRQ_CLR occur in the same cycle, set wins.
- irq = irq_status & IRQ_EN, registered-state only (no combinational path from the bus).
- Bits of writedata at or above WIDTH are ignored; readdata bits above WIDTH are 0.

Decomposition:
- Shared package sm_pio_pkg:
  - address constants ADDR_DATA/SET/CLR/CTRL;
  - CTRL bit indices;
  - state enum {IDLE, DEAD}.
- Sub-module sm_sync_edge (param STAGES): synchroniser plus rising-edge pulse, reusable for other SM inputs.
- Counter width: $clog2(DEAD_CYCLES+1), minimum 1.

Test Plan:
- Reset with WIDTH=2, RESET_VALUE=2 -> out_port=2, readdata@addr0=2, irq=0. Assert reset_n mid-DEAD -> out_port=2 immediately, FSM IDLE.
- Immediate mode, DEAD_CYCLES=4: write DATA=1 from out_port=2 -> out_port=0 for 4 cycles starting E1, then 1. irq_status=1; irq=0 until IRQ_EN set.
- Same-value write (DATA=1 while out_port=1) -> no dead gap; out_port stays 1; done and irq_status still set.
- SYNC_MODE=1, WIDTH=8: SET 0x0F, then CLR 0x03 -> out_port unchanged and PENDING=1. sync_in pulse -> out_port becomes 0x0C after SYNC_STAGES+1 plus dead time; PENDING=0.
- SYNC_MODE=1, pending: write FORCE -> apply without sync_in. sync_in pulse with pending=0 -> no change and no done.
- Write DATA=3 during DEAD of transition to 1 -> out_port=1 at end of dead time, PENDING=1. Second sequence follows: out_port 0 for DEAD_CYCLES, then 3. IRQ_CLR written on the done cycle -> irq_status remains 1.
